uart_tx_hold: RTL and testbench
===============================

# uart_tx_hold

Buffered UART transmitter: accepts one byte from the host through a single-word holding register and serializes it onto `tx`. It supports LSB-first framing with optional parity and a programmable stop length. It is the transmit-direction counterpart of the receiver plus one-word flag buffer path. It is driven by the shared 16x oversampling baud tick from the baud generator, and gives double buffering: the host may load the next byte while the current one is on the line.

## Interface
- `DBIT`, 8: number of data bits per frame, legal range 5–8; only `w_data[DBIT-1:0]` is sent.
- `SB_TICK`, 16: stop-bit length in `s_tick` periods; 16, 24 or 32 give 1, 1.5 or 2 stop bits.
- `PARITY`, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `s_tick`, in, 1: one-cycle enable pulse at 16x the baud rate.
- `wr`, in, 1: write strobe, sampled every cycle.
- `w_data`, in, 8: byte to transmit, captured when `wr` is accepted.
- `full`, out, 1: the holding register contains an unsent byte.
- `busy`, out, 1: the FSM is not idle.
- `tx`, out, 1: serial line, registered; idle level is high.
- `tx_done_tick`, out, 1: one-cycle pulse when a frame's stop period ends.

## Operation
- Holding register:
  - `wr` with `full`=0 captures `w_data` and sets `full` at that edge.
  - `wr` with `full`=1 is ignored. The held byte is not overwritten, and this holds even in the cycle `full` is being cleared.
- FSM states: IDLE, START, DATA, PAR, STOP. Tick counter `s` is 5 bits; bit index `n` is 3 bits.
- IDLE:
  - `tx`=1 and `busy`=0.
  - If `full`=1: copy the holding register to the shift register, clear `full`, set `s`=0, go to START. This does not wait for `s_tick`.
- START: `tx`=0. On each `s_tick`: if `s`=15, set `s`=0, `n`=0 and go to DATA; otherwise increment `s`.
- DATA:
  - `tx` = shift register bit 0.
  - On `s_tick` with `s`=15: shift right and set `s`=0.
  - If `n`=DBIT-1, go to PAR when `PARITY`≠0, else to STOP. Otherwise increment `n`.
- PAR:
  - Parity is computed over the `DBIT` data bits. Even mode sends the XOR of the bits; odd mode sends its inverse.
  - The state lasts 16 ticks, then goes to STOP.
- STOP:
  - `tx`=1.
  - On `s_tick` with `s`=SB_TICK-1: pulse `tx_done_tick` and go to IDLE.
  - If `full`=1 at that point, the next frame starts from IDLE on the following cycle, with no extra idle bit.
- `s_tick` high while in IDLE has no effect. Ticks are counted only in START, DATA, PAR and STOP.

## Timing
- Reset values: `tx`=1, `full`=0, `busy`=0, `tx_done_tick`=0; state IDLE, `s`=0, `n`=0. The shift and holding registers are cleared to 0.
- Reset asserted mid-frame aborts the frame on the next edge. `tx` returns to 1, the held byte is discarded, and no `tx_done_tick` is issued.
- `wr` accepted at edge k while idle:
  - `full`=1 after edge k.
  - At edge k+1: `full`=0, `busy`=1, `tx`=0.
- Frame length is 16·(1+DBIT+(PARITY≠0)) + SB_TICK ticks. With `s_tick` high every cycle in 8N1, that is 160 cycles from `tx` falling to `tx_done_tick`.
- The host may write the next byte on any cycle after `full` falls, which is one cycle after frame start.
- `tx_done_tick` is high for exactly one cycle per frame, coincident with the transition out of STOP.

## Structure
- Shared package `uart_pkg`:
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the tx state encoding;
  - the oversampling constant 16, shared with the receiver.
- Natural sub-module: `tx_hold_buf`, which contains the holding register and the `full` flag, with a `clr` input driven by the FSM's IDLE→START transition.
- Framing FSM, counters and parity generation stay in the top module.

## Test plan
- 8N1, `s_tick` every cycle, write 0x55:
  - `tx` sequence, 16 cycles per bit: 0, then 1,0,1,0,1,0,1,0, then 1.
  - `tx_done_tick` occurs 160 cycles after `tx` falls.
- `PARITY`=1, write 0x07: parity bit 1. `PARITY`=2, write 0x07: parity bit 0. `PARITY`=1, write 0x55: parity bit 0. Each frame is 176 ticks.
- Back-to-back writes of 0xA5 then 0x3C:
  - The second write lands one cycle after `full` falls.
  - The second start bit begins on the cycle after the first `tx_done_tick`, with no idle gap.
- Write 0x11, then write 0x22 while `full`=1: 0x22 is dropped and only the 0x11 frame is sent.
- `SB_TICK`=32, `s_tick` one cycle in every 4: the stop bit lasts 128 cycles. `busy` falls with `tx_done_tick`.
- Assert `reset` low at bit 3 of a frame with a byte held: on the next edge `tx`=1 and `full`=0, and no `tx_done_tick` occurs. A subsequent write of 0x81 is then transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, tx state encoding and parity helper
package uart_pkg;

    // Baud tick oversampling ratio, shared with the receiver.
    localparam int OVERSAMPLE = 16;

    // Parity modes.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    // Parity over the low dbit bits: plain XOR for even, inverted for odd.
    function automatic logic parity_bit(input logic [7:0] data, input int dbit, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < dbit) begin
                p = p ^ data[i];
            end
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/tx_hold_buf.sv
// rtl/tx_hold_buf.sv - single-word holding register with full flag
module tx_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_i,
    input  logic [W-1:0] w_data_i,
    input  logic         clr_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         full_q;
    logic         full_d;

    // A write is only taken while empty; the clearing edge always sees full set,
    // so a write landing on that edge is dropped rather than overwriting.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (wr_i && !full_q) begin
            full_d = 1'b1;
            data_d = w_data_i;
        end
    end

    // Holding register and flag state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/uart_tx_hold.sv
// rtl/uart_tx_hold.sv - buffered UART transmitter with single-word holding register
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = PAR_NONE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       wr,
    input  logic [7:0] w_data,
    output logic       full,
    output logic       busy,
    output logic       tx,
    output logic       tx_done_tick
);

    localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    tx_state_e  state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       done_q, done_d;
    logic       hold_clr;
    logic       hold_full;
    logic [7:0] hold_data;

    tx_hold_buf #(
        .W(8)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .wr_i     (wr),
        .w_data_i (w_data),
        .clr_i    (hold_clr),
        .full_o   (hold_full),
        .data_o   (hold_data)
    );

    // Framing FSM: next state, counters, shift register and the registered line level.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        shift_d  = shift_q;
        par_d    = par_q;
        done_d   = 1'b0;
        hold_clr = 1'b0;

        case (state_q)
            TX_IDLE: begin
                // Leaving idle does not wait for a tick, so a held byte goes out at once.
                if (hold_full) begin
                    shift_d  = hold_data;
                    par_d    = parity_bit(hold_data, DBIT, PARITY);
                    hold_clr = 1'b1;
                    s_d      = 5'd0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (s_tick) begin
                    if (s_q == TICK_LAST) begin
                        s_d     = 5'd0;
                        n_d     = 3'd0;
                        state_d = TX_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            TX_DATA: begin
                if (s_tick) begin
                    if (s_q == TICK_LAST) begin
                        s_d     = 5'd0;
                        shift_d = {1'b0, shift_q[7:1]};
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != PAR_NONE) ? TX_PAR : TX_STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            TX_PAR: begin
                if (s_tick) begin
                    if (s_q == TICK_LAST) begin
                        s_d     = 5'd0;
                        state_d = TX_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            TX_STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = 5'd0;
                        done_d  = 1'b1;
                        state_d = TX_IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx changes on the same edge.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            TX_PAR:   tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            s_q     <= 5'd0;
            n_q     <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign full         = hold_full;
    assign busy         = (state_q != TX_IDLE);
    assign tx           = tx_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_hold.sv
// tb/tb_uart_tx_hold.sv - self-checking bench for uart_tx_hold over several configurations
module tb_uart_tx_hold;

    localparam int ND   = 5;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic s_tick = 1'b0;
    logic wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [ND-1:0] tx_w, full_w, busy_w, done_w;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int tick_mode = 0;

    bit tx_h   [ND][HMAX];
    bit full_h [ND][HMAX];
    bit busy_h [ND][HMAX];
    bit done_h [ND][HMAX];

    bit       m_full  [ND];
    bit       m_act   [ND];
    bit       m_done  [ND];
    logic [7:0] m_hold  [ND];
    logic [7:0] m_frame [ND];
    int       m_ticks [ND];

    always #5 clk = ~clk;

    uart_tx_hold #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .wr(wr), .w_data(w_data),
        .full(full_w[0]), .busy(busy_w[0]), .tx(tx_w[0]), .tx_done_tick(done_w[0]));
    uart_tx_hold #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .wr(wr), .w_data(w_data),
        .full(full_w[1]), .busy(busy_w[1]), .tx(tx_w[1]), .tx_done_tick(done_w[1]));
    uart_tx_hold #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .wr(wr), .w_data(w_data),
        .full(full_w[2]), .busy(busy_w[2]), .tx(tx_w[2]), .tx_done_tick(done_w[2]));
    uart_tx_hold #(.DBIT(8), .SB_TICK(32), .PARITY(0)) dut3 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .wr(wr), .w_data(w_data),
        .full(full_w[3]), .busy(busy_w[3]), .tx(tx_w[3]), .tx_done_tick(done_w[3]));
    uart_tx_hold #(.DBIT(5), .SB_TICK(24), .PARITY(2)) dut4 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .wr(wr), .w_data(w_data),
        .full(full_w[4]), .busy(busy_w[4]), .tx(tx_w[4]), .tx_done_tick(done_w[4]));

    function automatic int cfg_dbit(int i);
        return (i == 4) ? 5 : 8;
    endfunction

    function automatic int cfg_sb(int i);
        return (i == 3) ? 32 : ((i == 4) ? 24 : 16);
    endfunction

    function automatic int cfg_par(int i);
        return (i == 1) ? 1 : ((i == 2 || i == 4) ? 2 : 0);
    endfunction

    function automatic int frame_ticks(int i);
        return 16 * (1 + cfg_dbit(i) + ((cfg_par(i) != 0) ? 1 : 0)) + cfg_sb(i);
    endfunction

    // Reference: a frame is a list of line levels, one per 16-tick slot, then the stop period.
    always @(posedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (!reset) begin
                m_full[i]  <= 1'b0;
                m_act[i]   <= 1'b0;
                m_done[i]  <= 1'b0;
                m_ticks[i] <= 0;
                m_hold[i]  <= 8'h00;
            end else begin
                m_done[i] <= 1'b0;
                if (m_act[i]) begin
                    if (s_tick) begin
                        if (m_ticks[i] + 1 == frame_ticks(i)) begin
                            m_act[i]  <= 1'b0;
                            m_done[i] <= 1'b1;
                        end
                        m_ticks[i] <= m_ticks[i] + 1;
                    end
                end else if (m_full[i]) begin
                    m_act[i]   <= 1'b1;
                    m_ticks[i] <= 0;
                    m_frame[i] <= m_hold[i];
                    m_full[i]  <= 1'b0;
                end
                if (wr && !m_full[i]) begin
                    m_full[i] <= 1'b1;
                    m_hold[i] <= w_data;
                end
            end
        end
    end

    function automatic logic model_level(int i);
        int   slot;
        int   db;
        logic p;
        slot = m_ticks[i] / 16;
        db   = cfg_dbit(i);
        if (!m_act[i]) return 1'b1;
        if (slot == 0) return 1'b0;
        if (slot <= db) return m_frame[i][slot-1];
        p = ^(m_frame[i] & 8'((1 << db) - 1));
        if (cfg_par(i) != 0 && slot == db + 1) return (cfg_par(i) == 2) ? ~p : p;
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_vec(int i);
        return {model_level(i), m_full[i], m_act[i], m_done[i]};
    endfunction

    function automatic logic [3:0] act_vec(int i);
        return {tx_w[i], full_w[i], busy_w[i], done_w[i]};
    endfunction

    function automatic int find_tx(int d, int from, bit v);
        for (int c = (from < 0 ? 0 : from); c < cyc && c < HMAX; c++) begin
            if (tx_h[d][c] == v) return c;
        end
        return -1;
    endfunction

    function automatic int find_done(int d, int from);
        for (int c = (from < 0 ? 0 : from); c < cyc && c < HMAX; c++) begin
            if (done_h[d][c]) return c;
        end
        return -1;
    endfunction

    function automatic int count_done(int d, int from, int to);
        int k;
        k = 0;
        for (int c = from; c < to && c < cyc && c < HMAX; c++) begin
            if (done_h[d][c]) k++;
        end
        return k;
    endfunction

    function automatic logic h_tx(int d, int c);
        if (c < 0 || c >= cyc || c >= HMAX) return 1'bx;
        return tx_h[d][c];
    endfunction

    function automatic logic [7:0] frame_byte(int d, int fall);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = h_tx(d, fall + 16 * (b + 1) + 8);
        return v;
    endfunction

    // Advance to the next falling edge, record outputs and set s_tick for the coming edge.
    task automatic step();
        @(negedge clk);
        if (cyc < HMAX) begin
            for (int i = 0; i < ND; i++) begin
                tx_h[i][cyc]   = tx_w[i];
                full_h[i][cyc] = full_w[i];
                busy_h[i][cyc] = busy_w[i];
                done_h[i][cyc] = done_w[i];
            end
        end
        cyc++;
        case (tick_mode)
            0:       s_tick = 1'b1;
            1:       s_tick = ((cyc % 4) == 0);
            default: s_tick = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic test_reset();
        cyc = 0; tick_mode = 0; reset = 1'b0; wr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL reset_state dut%0d cyc %0d got tx/full/busy/done=%b exp 1000", i, c, act_vec(i));
                end
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_8n1();
        int fall, done;
        logic [9:0] got, want;
        bit exp_line [10];
        exp_line = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        cyc = 0; tick_mode = 0;
        for (int c = 0; c < 220; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL 8n1_model dut%0d cyc %0d got %b exp %b", i, c, act_vec(i), exp_vec(i));
                end
            end
            if (c == 2) begin wr = 1'b1; w_data = 8'h55; end else wr = 1'b0;
        end
        fall = find_tx(0, 0, 1'b0);
        n_run++;
        if (fall != 4) begin
            n_fail++;
            $display("FAIL start_latency got sample %0d exp 4", fall);
        end
        n_run++;
        if ({full_h[0][3], full_h[0][4], busy_h[0][4], tx_h[0][4]} !== 4'b1010) begin
            n_fail++;
            $display("FAIL handoff got %b exp 1010", {full_h[0][3], full_h[0][4], busy_h[0][4], tx_h[0][4]});
        end
        done = find_done(0, 0);
        n_run++;
        if (done - fall != 160) begin
            n_fail++;
            $display("FAIL 8n1_done_delay got %0d exp 160", done - fall);
        end
        for (int b = 0; b < 10; b++) begin
            got[b]  = h_tx(0, fall + 16 * b + 8);
            want[b] = exp_line[b];
        end
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL 8n1_line got %b exp %b", got, want);
        end
    endtask

    task automatic test_parity();
        int f1, f2;
        cyc = 0; tick_mode = 0;
        for (int c = 0; c < 420; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL parity_model dut%0d cyc %0d got %b exp %b", i, c, act_vec(i), exp_vec(i));
                end
            end
            if (c == 2) begin wr = 1'b1; w_data = 8'h07; end
            else if (c == 202) begin wr = 1'b1; w_data = 8'h55; end
            else wr = 1'b0;
        end
        f1 = find_tx(1, 0, 1'b0);
        f2 = find_tx(1, 200, 1'b0);
        n_run++;
        if (h_tx(1, f1 + 16 * 9 + 8) !== 1'b1) begin
            n_fail++;
            $display("FAIL even_par_07 got %b exp 1", h_tx(1, f1 + 16 * 9 + 8));
        end
        n_run++;
        if (h_tx(2, f1 + 16 * 9 + 8) !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_par_07 got %b exp 0", h_tx(2, f1 + 16 * 9 + 8));
        end
        n_run++;
        if (h_tx(1, f2 + 16 * 9 + 8) !== 1'b0) begin
            n_fail++;
            $display("FAIL even_par_55 got %b exp 0", h_tx(1, f2 + 16 * 9 + 8));
        end
        n_run++;
        if (h_tx(2, f2 + 16 * 9 + 8) !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_par_55 got %b exp 1", h_tx(2, f2 + 16 * 9 + 8));
        end
        n_run++;
        if (find_done(1, 0) - f1 != 176 || find_done(2, 0) - f1 != 176) begin
            n_fail++;
            $display("FAIL parity_frame_len got %0d/%0d exp 176", find_done(1, 0) - f1, find_done(2, 0) - f1);
        end
    endtask

    task automatic test_back_to_back();
        int d1, f2;
        cyc = 0; tick_mode = 0;
        for (int c = 0; c < 380; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL b2b_model dut%0d cyc %0d got %b exp %b", i, c, act_vec(i), exp_vec(i));
                end
            end
            if (c == 2) begin wr = 1'b1; w_data = 8'hA5; end
            else if (c == 4) begin wr = 1'b1; w_data = 8'h3C; end
            else wr = 1'b0;
        end
        n_run++;
        if (full_h[0][5] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_write got full=%b exp 1", full_h[0][5]);
        end
        for (int i = 0; i < ND; i++) begin
            d1 = find_done(i, 0);
            f2 = find_tx(i, d1 < 0 ? cyc : d1, 1'b0);
            n_run++;
            if (d1 < 0 || f2 != d1 + 1) begin
                n_fail++;
                $display("FAIL b2b_gap dut%0d got start %0d exp %0d", i, f2, d1 + 1);
            end
        end
        d1 = find_done(0, 0);
        f2 = find_tx(0, d1 < 0 ? cyc : d1, 1'b0);
        n_run++;
        if (frame_byte(0, f2) !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_second_byte got %h exp 3c", frame_byte(0, f2));
        end
    endtask

    task automatic test_drop();
        int fall;
        cyc = 0; tick_mode = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL drop_model dut%0d cyc %0d got %b exp %b", i, c, act_vec(i), exp_vec(i));
                end
            end
            if (c == 2) begin wr = 1'b1; w_data = 8'h11; end
            else if (c == 3) begin wr = 1'b1; w_data = 8'h22; end
            else wr = 1'b0;
        end
        fall = find_tx(0, 0, 1'b0);
        n_run++;
        if (frame_byte(0, fall) !== 8'h11) begin
            n_fail++;
            $display("FAIL drop_kept_byte got %h exp 11", frame_byte(0, fall));
        end
        n_run++;
        if (count_done(0, 0, 200) != 1 || full_h[0][5] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_single_frame got dones=%0d full=%b exp 1/0", count_done(0, 0, 200), full_h[0][5]);
        end
    endtask

    task automatic test_sb32();
        int d, st;
        cyc = 0; tick_mode = 1;
        for (int c = 0; c < 760; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL sb32_model dut%0d cyc %0d got %b exp %b", i, c, act_vec(i), exp_vec(i));
                end
            end
            if (c == 2) begin wr = 1'b1; w_data = 8'h5A; end else wr = 1'b0;
        end
        d  = find_done(3, 0);
        st = -1;
        for (int c = d; c > 0; c--) begin
            if (tx_h[3][c] && !tx_h[3][c-1]) begin
                st = c;
                break;
            end
        end
        n_run++;
        if (d < 0 || st < 0 || d - st != 128) begin
            n_fail++;
            $display("FAIL sb32_stop_len got %0d exp 128", d - st);
        end
        n_run++;
        if (d < 1 || busy_h[3][d] !== 1'b0 || busy_h[3][d-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb32_busy_fall got done=%0d exp busy 1->0 at done", d);
        end
        tick_mode = 0;
    endtask

    task automatic test_reset_mid();
        int fall, d;
        cyc = 0; tick_mode = 0;
        for (int c = 0; c < 320; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL rstmid_model dut%0d cyc %0d got %b exp %b", i, c, act_vec(i), exp_vec(i));
                end
            end
            if (c == 74) begin
                for (int i = 0; i < ND; i++) begin
                    n_run++;
                    if (act_vec(i) !== 4'b1000) begin
                        n_fail++;
                        $display("FAIL rstmid_abort dut%0d got %b exp 1000", i, act_vec(i));
                    end
                end
            end
            reset = (c == 73) ? 1'b0 : 1'b1;
            if (c == 2) begin wr = 1'b1; w_data = 8'hF0; end
            else if (c == 6) begin wr = 1'b1; w_data = 8'h99; end
            else if (c == 120) begin wr = 1'b1; w_data = 8'h81; end
            else wr = 1'b0;
        end
        for (int i = 0; i < ND; i++) begin
            n_run++;
            if (count_done(i, 0, 121) != 0) begin
                n_fail++;
                $display("FAIL rstmid_no_done dut%0d got %0d exp 0", i, count_done(i, 0, 121));
            end
        end
        fall = find_tx(0, 100, 1'b0);
        d    = find_done(0, 100);
        n_run++;
        if (fall != 122 || d - fall != 160 || frame_byte(0, fall) !== 8'h81) begin
            n_fail++;
            $display("FAIL rstmid_after got start=%0d len=%0d byte=%h exp 122/160/81", fall, d - fall, frame_byte(0, fall));
        end
    endtask

    task automatic test_random();
        cyc = 0; tick_mode = 2;
        for (int c = 0; c < 8000; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                n_run++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random_model dut%0d cyc %0d got %b exp %b", i, c, act_vec(i), exp_vec(i));
                end
            end
            wr     = ($urandom_range(0, 99) < 4);
            w_data = 8'($urandom_range(0, 255));
            reset  = ($urandom_range(0, 2999) != 0);
        end
        reset = 1'b1;
        wr    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_drop();
        test_sb32();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
